// File: rtl/msx50bus_pkg.sv
// Shared definitions for the MSX 50-pin cartridge bus front end.
//   state_t       : transaction FSM states
//   RDATA_*       : data presented to the MSX when idle / after a forced completion
//   *_MIN / *_MAX : legal parameter ranges, checked at elaboration by the top
package msx50bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IGNORE,
    ST_REQ,
    ST_RDWAIT,
    ST_HOLD
  } state_t;

  localparam logic [7:0] RDATA_IDLE    = 8'h00;
  localparam logic [7:0] RDATA_TIMEOUT = 8'hFF;

  localparam int unsigned SYNC_STAGES_MIN    = 2;
  localparam int unsigned SYNC_STAGES_MAX    = 4;
  localparam int unsigned FILTER_LEN_MIN     = 1;
  localparam int unsigned FILTER_LEN_MAX     = 15;
  localparam int unsigned TIMEOUT_CYCLES_MIN = 1;
  localparam int unsigned TIMEOUT_CYCLES_MAX = 65535;

endpackage

// File: rtl/ip_msx50bus_sync_filter.sv
// Synchroniser plus glitch filter for one asynchronous active-low strobe.
//   clk   : system clock
//   reset : asynchronous active-high reset (chain and filter preset to 1)
//   din   : raw pin
//   dout  : filtered level, changes only after FILTER_LEN equal differing samples
module ip_msx50bus_sync_filter
  import msx50bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filt_q;
  logic [3:0]             cnt_q;
  logic                   accept;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // The accepted value is presented combinationally from registered state so the
  // decode sees a change on the same edge it is qualified, keeping pin-to-request
  // latency at SYNC_STAGES + FILTER_LEN clocks.
  always_comb begin
    accept = (synced != filt_q) && (cnt_q == 4'(FILTER_LEN - 1));
    dout   = accept ? synced : filt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= dout;
      if ((synced == filt_q) || accept) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ip_msx50bus_cart_ex.sv
// MSX 50-pin cartridge bus front end.
//   clk, reset                 : system clock, asynchronous active-high reset
//   adr, i_data                : MSX address / write data pins
//   o_data, is_output          : read data toward MSX and its drive enable
//   n_sltsl/n_rd/n_wr/n_ioreq  : MSX strobes, active low, asynchronous
//   n_mereq                    : synchronised but not decoded
//   wait_req                   : 1 = pull MSX /WAIT low
//   bus_*                      : level request/ack interface to the internal bus
//   timeout                    : sticky flag, set on any forced completion
module ip_msx50bus_cart_ex
  import msx50bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 2,
  parameter logic [7:0]  IO_BASE        = 8'h00,
  parameter logic [7:0]  IO_MASK        = 8'h00,
  parameter bit          WAIT_EN        = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] adr,
  input  logic [7:0]  i_data,
  output logic [7:0]  o_data,
  output logic        is_output,
  input  logic        n_sltsl,
  input  logic        n_rd,
  input  logic        n_wr,
  input  logic        n_ioreq,
  input  logic        n_mereq,
  output logic        wait_req,
  output logic [15:0] bus_address,
  output logic        bus_io_req,
  output logic        bus_memory_req,
  input  logic        bus_ack,
  output logic        bus_wrt,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_rdata_en,
  output logic        timeout
);

  if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if ((FILTER_LEN < FILTER_LEN_MIN) || (FILTER_LEN > FILTER_LEN_MAX)) begin : g_bad_filter
    $error("FILTER_LEN out of range");
  end
  if ((TIMEOUT_CYCLES < TIMEOUT_CYCLES_MIN) || (TIMEOUT_CYCLES > TIMEOUT_CYCLES_MAX)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  logic [4:0] pin_raw;
  logic [4:0] pin_filt;

  assign pin_raw = {n_mereq, n_ioreq, n_wr, n_rd, n_sltsl};

  for (genvar g = 0; g < 5; g++) begin : g_sync
    ip_msx50bus_sync_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
    ) u_sf (
      .clk  (clk),
      .reset(reset),
      .din  (pin_raw[g]),
      .dout (pin_filt[g])
    );
  end

  logic sltsl_f, rd_f, wr_f, ioreq_f;
  logic unused_mereq;

  assign sltsl_f      = pin_filt[0];
  assign rd_f         = pin_filt[1];
  assign wr_f         = pin_filt[2];
  assign ioreq_f      = pin_filt[3];
  assign unused_mereq = pin_filt[4];

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        io_req_q, io_req_d;
  logic        mem_req_q, mem_req_d;
  logic        wrt_q, wrt_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        is_out_q, is_out_d;
  logic        wait_q, wait_d;
  logic        to_q, to_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        txn_wr_q, txn_wr_d;

  logic rd_act, wr_act, strobe, mem_hit, io_hit, tmo_hit;

  always_comb begin
    rd_act  = ~rd_f;
    wr_act  = ~wr_f;
    strobe  = rd_act | wr_act;
    mem_hit = ~sltsl_f;
    io_hit  = ~ioreq_f & ((adr[7:0] & IO_MASK) == (IO_BASE & IO_MASK));
    tmo_hit = (tcnt_q == 16'(TIMEOUT_CYCLES - 1));

    state_d   = state_q;
    addr_d    = addr_q;
    io_req_d  = io_req_q;
    mem_req_d = mem_req_q;
    wrt_d     = wrt_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    is_out_d  = is_out_q;
    wait_d    = wait_q;
    to_d      = to_q;
    tcnt_d    = tcnt_q;
    txn_wr_d  = txn_wr_q;

    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          if (mem_hit || io_hit) begin
            addr_d    = adr;
            txn_wr_d  = wr_act;
            wrt_d     = wr_act;
            if (wr_act) begin
              wdata_d = i_data;
            end
            mem_req_d = mem_hit;
            io_req_d  = ~mem_hit;
            wait_d    = WAIT_EN;
            tcnt_d    = '0;
            state_d   = ST_REQ;
          end else begin
            state_d = ST_IGNORE;
          end
        end
      end

      ST_IGNORE: begin
        if (!strobe) begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (bus_ack) begin
          mem_req_d = 1'b0;
          io_req_d  = 1'b0;
          wrt_d     = 1'b0;
          if (txn_wr_q) begin
            wait_d  = 1'b0;
            state_d = ST_HOLD;
          end else if (bus_rdata_en) begin
            rdata_d  = bus_rdata;
            is_out_d = 1'b1;
            wait_d   = 1'b0;
            state_d  = ST_HOLD;
          end else begin
            state_d = ST_RDWAIT;
          end
        end else if (tmo_hit) begin
          mem_req_d = 1'b0;
          io_req_d  = 1'b0;
          wrt_d     = 1'b0;
          to_d      = 1'b1;
          wait_d    = 1'b0;
          if (!txn_wr_q) begin
            rdata_d  = RDATA_TIMEOUT;
            is_out_d = 1'b1;
          end
          state_d = ST_HOLD;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end

      ST_RDWAIT: begin
        if (bus_rdata_en) begin
          rdata_d  = bus_rdata;
          is_out_d = 1'b1;
          wait_d   = 1'b0;
          state_d  = ST_HOLD;
        end else if (tmo_hit) begin
          rdata_d  = RDATA_TIMEOUT;
          is_out_d = 1'b1;
          to_d     = 1'b1;
          wait_d   = 1'b0;
          state_d  = ST_HOLD;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end

      ST_HOLD: begin
        if (!strobe) begin
          rdata_d  = RDATA_IDLE;
          is_out_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      io_req_q  <= 1'b0;
      mem_req_q <= 1'b0;
      wrt_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= RDATA_IDLE;
      is_out_q  <= 1'b0;
      wait_q    <= 1'b0;
      to_q      <= 1'b0;
      tcnt_q    <= '0;
      txn_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      io_req_q  <= io_req_d;
      mem_req_q <= mem_req_d;
      wrt_q     <= wrt_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      is_out_q  <= is_out_d;
      wait_q    <= wait_d;
      to_q      <= to_d;
      tcnt_q    <= tcnt_d;
      txn_wr_q  <= txn_wr_d;
    end
  end

  assign bus_address    = addr_q;
  assign bus_io_req     = io_req_q;
  assign bus_memory_req = mem_req_q;
  assign bus_wrt        = wrt_q;
  assign bus_wdata      = wdata_q;
  assign o_data         = rdata_q;
  assign is_output      = is_out_q;
  assign wait_req       = wait_q;
  assign timeout        = to_q;

endmodule

// File: tb/tb_ip_msx50bus_cart_ex.sv
module tb_ip_msx50bus_cart_ex;

  localparam int TO = 16;
  localparam int SLEN_NORMAL = 36;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr;
  logic [7:0]  i_data;
  logic [7:0]  o_data;
  logic        is_output;
  logic        n_sltsl, n_rd, n_wr, n_ioreq, n_mereq;
  logic        wait_req;
  logic [15:0] bus_address;
  logic        bus_io_req, bus_memory_req;
  logic        bus_ack;
  logic        bus_wrt;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_rdata_en;
  logic        timeout;

  always #5 clk = ~clk;

  ip_msx50bus_cart_ex #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (3),
    .IO_BASE       (8'h98),
    .IO_MASK       (8'hFE),
    .WAIT_EN       (1'b1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .adr           (adr),
    .i_data        (i_data),
    .o_data        (o_data),
    .is_output     (is_output),
    .n_sltsl       (n_sltsl),
    .n_rd          (n_rd),
    .n_wr          (n_wr),
    .n_ioreq       (n_ioreq),
    .n_mereq       (n_mereq),
    .wait_req      (wait_req),
    .bus_address   (bus_address),
    .bus_io_req    (bus_io_req),
    .bus_memory_req(bus_memory_req),
    .bus_ack       (bus_ack),
    .bus_wrt       (bus_wrt),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_rdata_en  (bus_rdata_en),
    .timeout       (timeout)
  );

  typedef struct {
    bit          mem_sel;
    bit          io_sel;
    bit          rd;
    bit          wr;
    logic [15:0] a;
    logic [7:0]  wd;
    int          n;      // ack delay after request seen; <0 = never ack
    int          m;      // extra delay from ack to read data
    logic [7:0]  rdat;
    int          slen;   // strobe low duration in clocks
  } txn_t;

  typedef struct {
    logic [15:0] a;
    bit          wrt;
    logic [7:0]  wd;
    bit          is_mem;
    int          req_w;
    int          wait_w;
  } req_exp_t;

  req_exp_t   req_q[$];
  logic [7:0] data_q[$];

  int errors = 0;
  int checks = 0;

  bit         m_timeout = 1'b0;
  logic [7:0] m_wdata   = 8'h00;
  bit         abort     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(bit ms, bit is, bit r, bit w, logic [15:0] a, logic [7:0] wd,
                              int n, int m, logic [7:0] rdat, int slen);
    txn_t t;
    t.mem_sel = ms; t.io_sel = is; t.rd = r; t.wr = w;
    t.a = a; t.wd = wd; t.n = n; t.m = m; t.rdat = rdat; t.slen = slen;
    return t;
  endfunction

  // Monitor: pops expectations whenever the DUT raises a request or drives data.
  bit       prev_req = 0, prev_wait = 0, prev_out = 0, have_cur = 0;
  req_exp_t cur;
  int       req_cnt = 0, wait_cnt = 0;
  logic     mon_req;

  always @(negedge clk) begin
    mon_req = bus_io_req | bus_memory_req;
    if (mon_req) check("req_onehot", 64'(bus_io_req ^ bus_memory_req), 64'd1);
    if (mon_req && !prev_req) begin
      check("req_expected", 64'(req_q.size() != 0), 64'd1);
      if (req_q.size() != 0) begin
        cur = req_q.pop_front();
        check("req_fields", {bus_address, bus_wrt, bus_wdata, bus_memory_req},
              {cur.a, cur.wrt, cur.wd, cur.is_mem});
        have_cur = 1;
        req_cnt  = 0;
        wait_cnt = 0;
      end
    end
    if (mon_req) req_cnt++;
    if (wait_req) wait_cnt++;
    if (!mon_req && prev_req && have_cur) check("req_width", 64'(req_cnt), 64'(cur.req_w));
    if (!wait_req && prev_wait && have_cur) begin
      if (!abort) check("wait_width", 64'(wait_cnt), 64'(cur.wait_w));
      have_cur = 0;
    end
    if (is_output && !prev_out) begin
      check("data_expected", 64'(data_q.size() != 0), 64'd1);
      if (data_q.size() != 0) check("read_data", 64'(o_data), 64'(data_q.pop_front()));
    end
    prev_req  = mon_req;
    prev_wait = wait_req;
    prev_out  = is_output;
  end

  // Runs one MSX cycle; called at a negedge, returns at a negedge.
  task automatic run_txn(input txn_t t);
    bit         hit_mem, hit_io, wr_t, to, taken;
    req_exp_t   e;
    int         seen, j;
    logic [7:0] exp_d;
    hit_mem = t.mem_sel;
    hit_io  = t.io_sel && ((t.a[7:0] & 8'hFE) == 8'h98);
    wr_t    = t.wr;
    taken   = (hit_mem || hit_io) && (t.slen >= 3);
    to      = (t.n < 0);
    exp_d   = to ? 8'hFF : t.rdat;
    if (taken) begin
      if (wr_t) m_wdata = t.wd;
      e.a      = t.a;
      e.wrt    = wr_t;
      e.wd     = m_wdata;
      e.is_mem = hit_mem;
      e.req_w  = to ? TO : t.n + 1;
      e.wait_w = to ? TO : (wr_t ? t.n + 1 : t.n + t.m + 1);
      req_q.push_back(e);
      if (!wr_t) data_q.push_back(exp_d);
      if (to) m_timeout = 1'b1;
    end
    adr     = t.a;
    i_data  = t.wd;
    n_sltsl = !t.mem_sel;
    n_ioreq = !t.io_sel;
    n_rd    = !t.rd;
    n_wr    = !t.wr;
    seen    = -1;
    for (int k = 0; k < 48; k++) begin
      if (k == t.slen) begin
        n_rd = 1'b1; n_wr = 1'b1; n_sltsl = 1'b1; n_ioreq = 1'b1;
      end
      if (seen < 0 && (bus_io_req || bus_memory_req)) seen = k;
      if (k == t.slen - 1 && t.slen == SLEN_NORMAL && taken && !wr_t)
        check("read_data_hold", {is_output, o_data}, {1'b1, exp_d});
      if (k == 33 && t.slen == SLEN_NORMAL) begin
        bus_ack      = 1'b1;
        bus_rdata_en = 1'b1;
        bus_rdata    = 8'($urandom);
      end else if (seen >= 0) begin
        j            = k - seen;
        bus_ack      = !to && (j == t.n);
        bus_rdata_en = !to && !wr_t && (j == t.n + t.m);
        bus_rdata    = bus_rdata_en ? t.rdat : 8'($urandom);
      end else begin
        bus_ack      = 1'b0;
        bus_rdata_en = 1'b0;
      end
      @(negedge clk);
    end
    bus_ack      = 1'b0;
    bus_rdata_en = 1'b0;
    check("req_latency", 64'(seen), 64'(taken ? 5 : -1));
    check("release_idle", {is_output, o_data, bus_io_req, bus_memory_req, wait_req}, 64'd0);
    check("timeout_flag", 64'(timeout), 64'(m_timeout));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_data, is_output, wait_req, bus_address, bus_io_req, bus_memory_req,
                bus_wrt, bus_wdata, timeout});
  endfunction

  initial begin
    txn_t t;
    int   sel, dir, seen;
    reset = 1'b1;
    adr = '0; i_data = '0;
    n_sltsl = 1'b1; n_rd = 1'b1; n_wr = 1'b1; n_ioreq = 1'b1; n_mereq = 1'b1;
    bus_ack = 1'b0; bus_rdata = '0; bus_rdata_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", all_outs(), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset", all_outs(), 64'd0);

    // Directed cases
    run_txn(mk(1, 0, 0, 1, 16'h4000, 8'h5A, 3, 0, 8'h00, SLEN_NORMAL)); // memory write
    run_txn(mk(0, 1, 1, 0, 16'h1299, 8'h00, 3, 0, 8'hC3, SLEN_NORMAL)); // I/O read in window
    run_txn(mk(0, 1, 1, 0, 16'h129A, 8'h00, 3, 0, 8'hC3, SLEN_NORMAL)); // I/O read outside window
    run_txn(mk(1, 0, 1, 0, 16'h8123, 8'h00, 2, 4, 8'h11, SLEN_NORMAL)); // split read
    run_txn(mk(1, 0, 1, 0, 16'h8124, 8'h00, -1, 0, 8'h00, SLEN_NORMAL)); // read timeout
    run_txn(mk(1, 0, 1, 0, 16'h8125, 8'h00, 15, 0, 8'h3C, SLEN_NORMAL)); // ack in timeout cycle
    run_txn(mk(0, 1, 0, 1, 16'h0098, 8'hA7, 1, 0, 8'h00, SLEN_NORMAL)); // good write, flag sticky
    run_txn(mk(1, 0, 1, 0, 16'h4001, 8'h00, 1, 0, 8'h55, 2));           // 2-clock glitch
    run_txn(mk(1, 0, 0, 1, 16'h4002, 8'h66, 2, 0, 8'h00, 4));           // 4-clock pulse, early release
    run_txn(mk(1, 1, 1, 0, 16'h0098, 8'h00, 0, 0, 8'h77, SLEN_NORMAL)); // mem beats I/O
    run_txn(mk(1, 0, 1, 1, 16'hBEEF, 8'h42, 2, 0, 8'h00, SLEN_NORMAL)); // write beats read
    run_txn(mk(0, 1, 0, 1, 16'h0099, 8'h24, -1, 0, 8'h00, SLEN_NORMAL)); // write timeout
    run_txn(mk(0, 0, 1, 0, 16'h0098, 8'h00, 1, 0, 8'h00, SLEN_NORMAL)); // strobe, no select

    // Async reset while waiting for read data
    abort = 1'b1;
    req_q.push_back('{a: 16'h8000, wrt: 1'b0, wd: m_wdata, is_mem: 1'b1, req_w: 1, wait_w: 0});
    adr = 16'h8000; n_sltsl = 1'b0; n_rd = 1'b0;
    seen = -1;
    for (int k = 0; k < 12 && seen < 0; k++) begin
      if (bus_memory_req) seen = k;
      else @(negedge clk);
    end
    check("rst_req_seen", 64'(seen >= 0), 64'd1);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wait_before", 64'(wait_req), 64'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("reset_async", all_outs(), 64'd0);
    n_sltsl = 1'b1; n_rd = 1'b1;
    m_timeout = 1'b0;
    m_wdata   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b0;
    run_txn(mk(1, 0, 1, 0, 16'h8001, 8'h00, 1, 2, 8'h9E, SLEN_NORMAL));

    // Randomized cycles
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      dir = $urandom_range(0, 4);
      t.mem_sel = (sel <= 4) || (sel == 9);
      t.io_sel  = (sel >= 5);
      t.a       = 16'($urandom);
      if (t.io_sel && $urandom_range(0, 2) != 0) t.a[7:0] = {7'h4C, 1'($urandom)};
      t.rd   = (dir <= 1) || (dir == 4);
      t.wr   = (dir >= 2);
      t.wd   = 8'($urandom);
      t.rdat = 8'($urandom);
      t.n    = $urandom_range(0, 8);
      t.m    = $urandom_range(0, 4);
      t.slen = SLEN_NORMAL;
      run_txn(t);
    end

    check("sb_req_empty", 64'(req_q.size()), 64'd0);
    check("sb_data_empty", 64'(data_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got time limit expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ip_msx50bus_cart_ex.md
Name: ip_msx50bus_cart_ex

Overview:
Parametrised successor to the MSX 50-pin cartridge bus front end. It brings the asynchronous slot strobes into the clk domain through a configurable synchroniser and glitch filter. It decodes memory (SLTSL) and I/O (IOREQ with port-window match) cycles, runs a request/ack/read-data FSM against the internal bus, and drives the MSX /WAIT request while a transaction is outstanding. A timeout prevents the MSX from hanging on a missing ack.

Parameters:
SYNC_STAGES, 2, synchroniser flops per strobe input (legal 2..4)
FILTER_LEN, 2, consecutive equal synced samples required before a filtered strobe changes (1 = no filter, max 15)
IO_BASE, 8'h00, I/O port window base (compared under IO_MASK)
IO_MASK, 8'h00, I/O port bits compared; 8'h00 accepts every port
WAIT_EN, 1, 1 = drive wait_req during outstanding transactions; 0 = wait_req tied 0
TIMEOUT_CYCLES, 255, clocks in REQ/RDWAIT before forced completion (legal 1..65535)

Ports:
clk  in  1  system clock; the only clock
reset  in  1  asynchronous, active-high reset
adr  in  16  MSX address pins
i_data  in  8  MSX data pins, input direction
o_data  out  8  read data toward MSX
is_output  out  1  1 = drive MSX data bus with o_data
n_sltsl  in  1  slot select, active low
n_rd  in  1  read strobe, active low
n_wr  in  1  write strobe, active low
n_ioreq  in  1  I/O request, active low
n_mereq  in  1  memory request, active low; synchronised, reserved, not decoded
wait_req  out  1  1 = pull MSX /WAIT low (open-drain at pad)
bus_address  out  16  latched transaction address
bus_io_req  out  1  I/O request, level, held until bus_ack
bus_memory_req  out  1  memory request, level, held until bus_ack
bus_ack  in  1  target accepted request
bus_wrt  out  1  1 = write transaction; valid while a req is high
bus_wdata  out  8  latched write data
bus_rdata  in  8  read data
bus_rdata_en  in  1  bus_rdata valid this cycle
timeout  out  1  sticky; set on any forced completion; cleared only by reset

Behaviour:
- Reset (async, immediate): every sync flop = 1, filtered strobes = 1 (inactive), FSM = IDLE, every bus_* output = 0, o_data = 8'h00, is_output = 0, wait_req = 0, timeout = 0. An assertion mid-transaction aborts it with no ack required.
- Sync/filter: each of n_sltsl, n_rd, n_wr, n_ioreq, n_mereq passes through SYNC_STAGES flops. The filter counter reloads on any mismatch. The filtered value updates on the FILTER_LEN-th consecutive sample differing from the current filtered value. Latency, pin change to bus_*_req high: SYNC_STAGES + FILTER_LEN clocks (3 for SYNC_STAGES=2, FILTER_LEN=1).
- Decode on filtered signals: strobe = ~rd | ~wr; mem_hit = ~sltsl; io_hit = ~ioreq & ((adr[7:0] & IO_MASK) == (IO_BASE & IO_MASK)). mem_hit takes priority if both are true. A write takes priority if rd and wr are both low.
- IDLE:
  - strobe & hit: latch adr into bus_address. On a write, latch i_data into bus_wdata and set bus_wrt=1. Raise the matching req, set wait_req=WAIT_EN, clear the timeout counter, go to REQ.
  - strobe & no hit: go to IGNORE.
- IGNORE: no outputs change; return to IDLE when strobe is released (rd & wr both high).
- REQ: req held while bus_ack=0.
  - On bus_ack: drop req and bus_wrt.
  - Write: go to HOLD.
  - Read with bus_rdata_en in the same cycle: o_data=bus_rdata, is_output=1, go to HOLD.
  - Read without bus_rdata_en: go to RDWAIT.
- RDWAIT: on bus_rdata_en, o_data=bus_rdata, is_output=1, go to HOLD.
- Timeout: counter increments each cycle in REQ/RDWAIT. On reaching TIMEOUT_CYCLES: drop req and bus_wrt, set timeout=1, go to HOLD. For a read, also set o_data=8'hFF and is_output=1. An ack arriving in the timeout cycle wins; the timeout is not flagged.
- HOLD: wait_req=0 on entry, registered, so it drops on the same edge the FSM enters HOLD. On strobe release, o_data=8'h00, is_output=0, go to IDLE. bus_ack/bus_rdata_en in HOLD, IDLE or IGNORE are ignored.
- Strobe released early in REQ/RDWAIT (protocol violation): keep waiting for ack or timeout, then HOLD exits on the next cycle.
- Exactly one of bus_io_req/bus_memory_req is high at a time. Requests are levels, never pulses. Registered outputs only; wait_req must not glitch.

Decomposition:
- Package msx50bus_pkg: FSM state encoding (IDLE, IGNORE, REQ, RDWAIT, HOLD), constants RDATA_IDLE=8'h00 and RDATA_TIMEOUT=8'hFF, and the parameter legality ranges.
- Sub-module ip_msx50bus_sync_filter (params SYNC_STAGES, FILTER_LEN; reset value 1), instantiated once per strobe.

Test Plan:
- Memory write: sltsl=0, adr=16'h4000, i_data=8'h5A, wr low 20 clk; ack after 3 clk -> bus_memory_req=1, bus_wrt=1, bus_address=16'h4000, bus_wdata=8'h5A; wait_req high until ack; is_output stays 0.
- I/O read window: IO_BASE=8'h98, IO_MASK=8'hFE; read port 8'h99 with ack+rdata_en=8'hC3 same cycle -> o_data=8'hC3, is_output=1 until rd high. Read port 8'h9A -> no req, IGNORE.
- Split read: ack at cycle 2, rdata_en=8'h11 at cycle 6 -> wait_req held through RDWAIT; o_data=8'h11.
- Timeout: TIMEOUT_CYCLES=16, read with no ack -> req drops after 16 clk, o_data=8'hFF, timeout=1 sticky across later good cycles.
- Glitch: FILTER_LEN=3, 2-clk-wide rd low pulse -> no request. 4-clk pulse -> request at SYNC_STAGES+3 clk.
- Async reset asserted in RDWAIT between clock edges -> all outputs zero immediately; the next read completes normally.
